fp_mul_seq_ctrl: RTL and testbench
==================================

# fp_mul_seq_ctrl

Multi-cycle sequencer for the single-precision FP multiplier datapath. It accepts two IEEE-754 binary32 operands over a valid/ready handshake and forms the 48-bit mantissa product with an iterative shift-add. It then normalizes, rounds to nearest-even, and runs the exponent-update step (bias removal, +ovf, +ovf_rnd, overflow/underflow detection) before presenting the result over a second valid/ready handshake. It sits between the FPU operand dispatch and the FPU result writeback, one operation in flight.

## Interface

Parameters:
- BITS_PER_CYCLE, default 1, multiplier bits consumed per MUL cycle. Legal values are 1, 2, 3, 4; each gives N = 24/BITS_PER_CYCLE MUL cycles.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; high only in IDLE and while rst is low.
- a  in  32  operand A, binary32.
- b  in  32  operand B, binary32.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- z  out  32  product, binary32.
- overflow_flag  out  1  result saturated to ±inf.
- underflow_flag  out  1  result flushed to ±0.
- invalid_flag  out  1  invalid operation; tied 0 without FP_MUL_SPECIALS_EN.
- busy  out  1  state is not IDLE.

## Operation

States: IDLE, MUL, NORM, ROUND, DONE.

- **IDLE**: in_ready=1. On in_valid&&in_ready, capture the operands:
  - sign = a[31]^b[31].
  - exp_sum = ea + eb − 127, computed in 10-bit two's complement.
  - Mantissas get the hidden bit prepended.
  - If either exponent field is 0 (zero or denormal, treated as zero), go to DONE with z={sign,31'b0} and all flags 0.
  - Otherwise clear the 48-bit product and the counter, and go to MUL.
- **MUL**: each cycle, for each of BITS_PER_CYCLE multiplier LSBs, add the multiplicand shifted left by its bit position into the product. The counter increments; after N cycles go to NORM.
- **NORM**:
  - If product[47]=1: ovf=1, mant=product[46:24], guard=product[23], sticky=|product[22:0].
  - Else: ovf=0, mant=product[45:23], guard=product[22], sticky=|product[21:0].
  - Go to ROUND.
- **ROUND**:
  - round_up = guard & (sticky | mant[0]).
  - If mant is all-ones and round_up=1: ovf_rnd=1 and mant=0. Otherwise mant += round_up and ovf_rnd=0.
  - internal = exp_sum + ovf + ovf_rnd, 10-bit signed.
  - internal ≥ 255 (signed): z={sign,8'hFF,23'b0}, overflow_flag=1.
  - internal ≤ 0 (signed): z={sign,31'b0}, underflow_flag=1. Results in this range are flushed; no denormal outputs are produced.
  - Otherwise z={sign,internal[7:0],mant}.
  - Go to DONE.
- **DONE**: out_valid=1. z and flags hold until out_ready=1, then return to IDLE.

Other rules:
- z and flags update only on entry to DONE. They keep their values in IDLE until the next DONE entry.
- No operand is accepted in DONE, even when out_ready=1 in the same cycle. The next accept is possible one cycle later in IDLE.

## Timing

- Reset values: state=IDLE, out_valid=0, z=0, overflow_flag=0, underflow_flag=0, invalid_flag=0, busy=0. in_ready=0 while rst=1.
- Reset asserted in any state aborts the operation; no out_valid is produced.
- Normal latency: out_valid rises N+3 cycles after the accepting edge (27 cycles for BITS_PER_CYCLE=1, 9 for 4).
- Zero and special fast path: out_valid rises 1 cycle after the accepting edge.
- Throughput: one operation per (latency + 1 + back-pressure cycles).

## Configuration

- Macro: FP_MUL_SPECIALS_EN.
- Defined: operands with exponent field 255 take the fast path. Checks run in priority order:
  1. NaN in either operand, or inf×0: z=32'h7FC00000, invalid_flag=1.
  2. inf×finite nonzero: z={sign,8'hFF,23'b0}, no flags.
- Not defined: exponent 255 is treated as an ordinary biased exponent in the normal path, which normally ends in overflow. invalid_flag is constant 0.

## Test plan

- 0x3FC00000 × 0x40000000 (1.5×2.0), BITS_PER_CYCLE=1 -> z=0x40400000, out_valid 27 cycles after accept, all flags 0.
- 0x7F000000 × 0x40000000 -> z=0x7F800000, overflow_flag=1, underflow_flag=0.
- 0x00800000 × 0x3F000000 (internal=0) -> z=0x00000000, underflow_flag=1.
- 0x80000000 × 0x40000000 -> z=0x80000000, out_valid 1 cycle after accept, no flags.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands present -> z and flags stable, in_ready=0, new operands not accepted; accepted 1 cycle after the out_ready handshake.
- Assert rst during MUL cycle 10 -> out_valid stays 0, all outputs at reset values, in_ready=1 on the first cycle after rst deasserts.

Source files
------------

// File: rtl/fp_mul_seq_ctrl.sv
// fp_mul_seq_ctrl: multi-cycle binary32 multiplier sequencer.
// Shift-add mantissa product, normalize, round-to-nearest-even, exponent
// update with saturating overflow and flush-to-zero underflow.
// Optional macro FP_MUL_SPECIALS_EN: NaN/inf operands take the fast path and
// invalid_flag becomes live; otherwise exponent 255 is an ordinary exponent.
module fp_mul_seq_ctrl #(
  parameter int unsigned BITS_PER_CYCLE = 1  // legal: 1, 2, 3, 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic        overflow_flag,
  output logic        underflow_flag,
  output logic        invalid_flag,
  output logic        busy
);

  localparam int unsigned N_CYCLES = 24 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned EXP_W    = 10;
  localparam int unsigned PROD_W   = 48;
  localparam int unsigned MANT_W   = 23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_sum_q, exp_sum_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [23:0]         mplier_q, mplier_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic                guard_q, guard_d;
  logic                sticky_q, sticky_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         z_q, z_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic                unf_flag_q, unf_flag_d;
  logic                inv_flag_q, inv_flag_d;

  logic                op_sign;
  logic                a_zero, b_zero;
  logic                fast_hit;
  logic [31:0]         fast_z;
  logic                fast_inv;
  logic [PROD_W-1:0]   prod_acc;
  logic                round_up;
  logic                ovf_rnd;
  logic [MANT_W-1:0]   mant_rnd;
  logic [EXP_W-1:0]    internal_exp;

  assign op_sign = a[31] ^ b[31];
  assign a_zero  = (a[30:23] == 8'h00);
  assign b_zero  = (b[30:23] == 8'h00);

`ifdef FP_MUL_SPECIALS_EN
  logic a_inf, b_inf, a_nan, b_nan;
  assign a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
  assign b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
  assign a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  assign b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
`endif

  // Fast-path classification of the incoming operand pair
  always_comb begin
    fast_hit = a_zero | b_zero;
    fast_z   = {op_sign, 31'h0};
    fast_inv = 1'b0;
`ifdef FP_MUL_SPECIALS_EN
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      fast_hit = 1'b1;
      fast_z   = 32'h7FC0_0000;
      fast_inv = 1'b1;
    end else if (a_inf || b_inf) begin
      fast_hit = 1'b1;
      fast_z   = {op_sign, 8'hFF, 23'h0};
    end
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_sum_d  = exp_sum_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    mant_d     = mant_q;
    guard_d    = guard_q;
    sticky_d   = sticky_q;
    ovf_d      = ovf_q;
    z_d        = z_q;
    ovf_flag_d = ovf_flag_q;
    unf_flag_d = unf_flag_q;
    inv_flag_d = inv_flag_q;
    prod_acc     = prod_q;
    round_up     = 1'b0;
    ovf_rnd      = 1'b0;
    mant_rnd     = mant_q;
    internal_exp = exp_sum_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d    = op_sign;
          exp_sum_d = {2'b00, a[30:23]} + {2'b00, b[30:23]} - EXP_W'(127);
          mcand_d   = PROD_W'({1'b1, a[22:0]});
          mplier_d  = {1'b1, b[22:0]};
          prod_d    = '0;
          cnt_d     = '0;
          if (fast_hit) begin
            z_d        = fast_z;
            ovf_flag_d = 1'b0;
            unf_flag_d = 1'b0;
            inv_flag_d = fast_inv;
            state_d    = S_DONE;
          end else begin
            state_d = S_MUL;
          end
        end
      end

      S_MUL: begin
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
          if (mplier_q[5'(i)]) prod_acc = prod_acc + (mcand_q << i);
        end
        prod_d   = prod_acc;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_CYCLES - 1)) state_d = S_NORM;
      end

      S_NORM: begin
        if (prod_q[47]) begin
          ovf_d    = 1'b1;
          mant_d   = prod_q[46:24];
          guard_d  = prod_q[23];
          sticky_d = |prod_q[22:0];
        end else begin
          ovf_d    = 1'b0;
          mant_d   = prod_q[45:23];
          guard_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
        end
        state_d = S_ROUND;
      end

      S_ROUND: begin
        round_up     = guard_q & (sticky_q | mant_q[0]);
        ovf_rnd      = (&mant_q) & round_up;
        // An all-ones mantissa wraps to zero on round-up; ovf_rnd bumps the exponent
        mant_rnd     = mant_q + MANT_W'(round_up);
        internal_exp = exp_sum_q + EXP_W'(ovf_q) + EXP_W'(ovf_rnd);
        inv_flag_d   = 1'b0;
        if ($signed(internal_exp) >= $signed(EXP_W'(255))) begin
          z_d        = {sign_q, 8'hFF, 23'h0};
          ovf_flag_d = 1'b1;
          unf_flag_d = 1'b0;
        end else if ($signed(internal_exp) <= $signed(EXP_W'(0))) begin
          z_d        = {sign_q, 31'h0};
          ovf_flag_d = 1'b0;
          unf_flag_d = 1'b1;
        end else begin
          z_d        = {sign_q, internal_exp[7:0], mant_rnd};
          ovf_flag_d = 1'b0;
          unf_flag_d = 1'b0;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      exp_sum_q  <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      mant_q     <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      ovf_q      <= 1'b0;
      z_q        <= '0;
      ovf_flag_q <= 1'b0;
      unf_flag_q <= 1'b0;
      inv_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_sum_q  <= exp_sum_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      mant_q     <= mant_d;
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
      ovf_q      <= ovf_d;
      z_q        <= z_d;
      ovf_flag_q <= ovf_flag_d;
      unf_flag_q <= unf_flag_d;
      inv_flag_q <= inv_flag_d;
    end
  end

  assign in_ready       = (state_q == S_IDLE) && !rst;
  assign out_valid      = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);
  assign z              = z_q;
  assign overflow_flag  = ovf_flag_q;
  assign underflow_flag = unf_flag_q;
`ifdef FP_MUL_SPECIALS_EN
  assign invalid_flag   = inv_flag_q;
`else
  assign invalid_flag   = 1'b0;
  logic unused_inv;
  assign unused_inv     = inv_flag_q;
`endif

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Directed bench for fp_mul_seq_ctrl (BITS_PER_CYCLE=1, specials disabled).
module tb_fp_mul_seq_ctrl;

  localparam int unsigned LAT_NORM = 27;
  localparam int unsigned LAT_FAST = 1;
  localparam int unsigned LAT_MAX  = 200;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic        overflow_flag;
  logic        underflow_flag;
  logic        invalid_flag;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  fp_mul_seq_ctrl #(.BITS_PER_CYCLE(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .z              (z),
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag),
    .invalid_flag   (invalid_flag),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count, and report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands in IDLE, wait (bounded) for out_valid; lat counts the accept edge as 1
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < int'(LAT_MAX)) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ez, input logic eovf, input logic eunf,
                         input int elat);
    int lat;
    start_op(av, bv, lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_z"}, z, ez);
    check({tag, "_ovf"}, 32'(overflow_flag), 32'(eovf));
    check({tag, "_unf"}, 32'(underflow_flag), 32'(eunf));
    check({tag, "_inv"}, 32'(invalid_flag), 32'h0);
    finish_op();
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] z_hold;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_z", z, 32'h0);
    check("rst_flags", {29'h0, overflow_flag, underflow_flag, invalid_flag}, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    // Normal path and rounding corners
    run_vec("mul_1p5x2",  32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, LAT_NORM);
    run_vec("ovf",        32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0, LAT_NORM);
    run_vec("unf",        32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, LAT_NORM);
    run_vec("zero_fast",  32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0, LAT_FAST);
    run_vec("neg_m2x3",   32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, 1'b0, LAT_NORM);
    run_vec("prod_ovf",   32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 1'b0, 1'b0, LAT_NORM);
    run_vec("rnd_carry",  32'h3FFF_FFFE, 32'h3F80_0001, 32'h4000_0000, 1'b0, 1'b0, LAT_NORM);
    run_vec("tie_odd_up", 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 1'b0, 1'b0, LAT_NORM);
    run_vec("tie_even",   32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 1'b0, 1'b0, LAT_NORM);
    run_vec("sticky_dn",  32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0, 1'b0, LAT_NORM);
    run_vec("exp255",     32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b1, 1'b0, LAT_NORM);
    check("idle_z_hold", z, 32'h7F80_0000);
    check("idle_ovf_hold", 32'(overflow_flag), 32'h1);

    // Back-pressure in DONE with a new operand pair waiting
    start_op(32'h3FC0_0000, 32'h4000_0000, lat);
    check("bp_lat", 32'(lat), 32'(LAT_NORM));
    a = 32'h4000_0000;
    b = 32'h4000_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_z", z, 32'h4040_0000);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_flags", {30'h0, overflow_flag, underflow_flag}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_busy", 32'(busy), 32'h0);
    check("bp_hs_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept_busy", 32'(busy), 32'h1);
    lat = 1;
    while (!out_valid && lat < int'(LAT_MAX)) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_next_lat", 32'(lat), 32'(LAT_NORM));
    check("bp_next_z", z, 32'h4080_0000);
    finish_op();

    // Reset mid-MUL aborts the operation
    a = 32'h3FC0_0000;
    b = 32'h4000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_in_ready", 32'(in_ready), 32'h0);
    check("abort_z", z, 32'h0);
    check("abort_flags", {29'h0, overflow_flag, underflow_flag, invalid_flag}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready_after", 32'(in_ready), 32'h1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
